// File: rtl/fp8_to_fixed.sv
// FP8 E5M2 to signed fixed-point converter with a one-bit-per-cycle denormalizing shifter.
// Optional round-to-nearest-even when FP8_TO_FIXED_ROUND_EN is defined; truncates otherwise.
`timescale 1ns/1ps
module fp8_to_fixed #(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           fp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] fx_out,
  output logic                 ovf_out
);

  localparam int unsigned KW = $clog2(FRAC_WIDTH + 15) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] mag_q, mag_d;
  logic [OUT_WIDTH-1:0] fx_q, fx_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 sign_q, sign_d;
  logic                 left_q, left_d;
  logic                 g_q, g_d;
  logic                 s_q, s_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;

  logic                 rnd_inc;
  logic [OUT_WIDTH:0]   rnd_sum;
  logic [OUT_WIDTH-1:0] rnd_mag;
  logic                 rnd_ovf;
  logic [4:0]           exp_in;
  int                   sh;

`ifdef FP8_TO_FIXED_ROUND_EN
  assign rnd_inc = g_q & (s_q | mag_q[0]);
`else
  assign rnd_inc = 1'b0;
`endif

  assign exp_in = fp_in[6:2];

  always_comb begin
    rnd_sum = {1'b0, mag_q} + {{OUT_WIDTH{1'b0}}, rnd_inc};
    // Any value at or above 2^(OUT_WIDTH-1) saturates symmetrically.
    rnd_ovf = sat_q | rnd_sum[OUT_WIDTH] | rnd_sum[OUT_WIDTH-1];
    rnd_mag = rnd_ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : rnd_sum[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    fx_d    = fx_q;
    k_d     = k_q;
    sign_d  = sign_q;
    left_d  = left_q;
    g_d     = g_q;
    s_d     = s_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    sh      = int'(exp_in) - 17 + int'(FRAC_WIDTH);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = fp_in[7];
          mag_d  = {{(OUT_WIDTH-3){1'b0}}, 1'b1, fp_in[1:0]};
          g_d    = 1'b0;
          s_d    = 1'b0;
          sat_d  = 1'b0;
          left_d = (sh >= 0);
          if (sh >= 0)
            k_d = KW'(sh);
          else if (sh < -4)
            k_d = KW'(4);
          else
            k_d = KW'(-sh);
          if (exp_in == 5'd0) begin
            mag_d = '0;
            k_d   = '0;
          end
          if (exp_in == 5'd31) begin
            sat_d = 1'b1;
            k_d   = '0;
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (k_q == '0 || mag_q[OUT_WIDTH-1]) begin
          if (mag_q[OUT_WIDTH-1])
            sat_d = 1'b1;
          state_d = ROUND;
        end else begin
          k_d = k_q - KW'(1);
          if (left_q) begin
            mag_d = {mag_q[OUT_WIDTH-2:0], 1'b0};
          end else begin
            g_d   = mag_q[0];
            s_d   = s_q | g_q;
            mag_d = {1'b0, mag_q[OUT_WIDTH-1:1]};
          end
        end
      end
      ROUND: begin
        ovf_d   = rnd_ovf;
        fx_d    = sign_q ? -rnd_mag : rnd_mag;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      fx_q    <= '0;
      k_q     <= '0;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      fx_q    <= fx_d;
      k_q     <= k_d;
      sign_q  <= sign_d;
      left_q  <= left_d;
      g_q     <= g_d;
      s_q     <= s_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign fx_out    = fx_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_fp8_to_fixed.sv
// Scoreboard bench for fp8_to_fixed: expected words come from an arithmetic E5M2 decode model.
`timescale 1ns/1ps
module tb_fp8_to_fixed;

  localparam int OW = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    fp_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] fx_out;
  logic          ovf_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]    fp;
    logic [OW-1:0] fx;
    logic          ovf;
    int            lat;
  } exp_t;

  exp_t sb[$];

  fp8_to_fixed #(.OUT_WIDTH(OW), .FRAC_WIDTH(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fx_out    (fx_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  // Value = {1,man} * 2^(exp-17); scaled by 2^FW, rounded, saturated.
  function automatic exp_t model(input logic [7:0] fp);
    exp_t   r;
    int     e;
    int     sh;
    int     n;
    longint m;
    longint mag;
    longint q;
    longint rem;
    longint half;
    longint lim;
    e   = int'(fp[6:2]);
    m   = 4 + longint'(fp[1:0]);
    sh  = e - 17 + FW;
    lim = (longint'(1) << (OW - 1)) - 1;
    r.fp  = fp;
    r.ovf = 1'b0;
    if (e == 0) begin
      mag   = 0;
      r.lat = 2;
    end else if (e == 31) begin
      mag   = lim + 1;
      r.lat = 2;
    end else if (sh >= 0) begin
      mag   = m << sh;
      r.lat = 2 + ((sh < OW - 3) ? sh : OW - 3);
    end else begin
      n    = -sh;
      q    = m >> n;
      rem  = m - (q << n);
      half = longint'(1) << (n - 1);
`ifdef FP8_TO_FIXED_ROUND_EN
      if (rem > half || (rem == half && (q % 2) == 1))
        q = q + 1;
`endif
      mag   = q;
      r.lat = 2 + ((n > 4) ? 4 : n);
    end
    if (mag > lim) begin
      r.ovf = 1'b1;
      mag   = lim;
    end
    r.fx = fp[7] ? OW'(-mag) : OW'(mag);
    return r;
  endfunction

  task automatic run_one(input logic [7:0] fp, input int hold);
    exp_t e;
    int   cnt;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    fp_in     = fp;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    sb.push_back(model(fp));
    @(negedge clk);
    in_valid = 1'b0;
    fp_in    = 8'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("sb_size", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check($sformatf("latency_%02h", fp), cnt, e.lat);
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_fx", fx_out, e.fx);
      check("hold_ovf", ovf_out, e.ovf);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check($sformatf("fx_%02h", fp), fx_out, e.fx);
    check($sformatf("ovf_%02h", fp), ovf_out, e.ovf);
    check("out_valid_done", out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_xfer", out_valid, 0);
    check("in_ready_after_xfer", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir [12];
    logic       seen;
    dir = '{8'h3C, 8'hBE, 8'h33, 8'h78, 8'hF8, 8'h7C, 8'h01, 8'h00,
            8'h80, 8'hFC, 8'h7F, 8'hB3};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    fp_in     = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fx", fx_out, 0);
    check("rst_ovf", ovf_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (dir[i]) run_one(dir[i], 0);
    run_one(8'h3C, 10);
    repeat (40) run_one(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));

    // Reset while the 0x78 conversion is mid-shift.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fp_in     = 8'h78;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_fx", fx_out, 0);
    check("async_rst_ovf", ovf_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("no_out_valid_after_rst", seen, 0);
    run_one(8'h3C, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
